sb_motor_arbiter: RTL and testbench
===================================

Name: sb_motor_arbiter

Overview:
- Owns the left/right motor drive pins (l_motor, r_motor, gndl, gndr) and shares them between three requesters:
  - line follower: default owner
  - bot-turn engine
  - hold requester: colour read / arm pick-place, bot must stand still
- Inserts a break-before-make dead time on every owner change and runs a watchdog on turns.
- Sits between the motion sub-blocks and the motor driver pins. It replaces the ad-hoc motor mux inside the top-level FSM.

Parameters:
- DEADTIME_CYC, 2500: cycles of all-off drive between owners (50 us at 50 MHz).
- TIMEOUT_CYC, 25000000: maximum cycles a turn may hold the motors (0.5 s).
- CNT_W, 25: width of the shared dead-time/watchdog counter; must hold max(DEADTIME_CYC, TIMEOUT_CYC).

Ports:
- clk_50  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- lf_l_motor  in  1  line-follower left drive
- lf_r_motor  in  1  line-follower right drive
- turn_req  in  1  bot-turn engine requests motors; level, held until done
- turn_l_motor, turn_r_motor, turn_gndl, turn_gndr  in  1 each  turn-engine drive
- turn_done  in  1  turn complete pulse/level
- turn_grant  out  1  turn engine owns motors
- hold_req  in  1  colour/arm requests bot stopped; level
- hold_grant  out  1  motors stopped and held for requester
- l_motor, r_motor, gndl, gndr  out  1 each  registered motor pin drive
- owner  out  2  0=NONE, 1=LF, 2=TURN, 3=HOLD
- fault  out  1  sticky turn-watchdog fault

Behaviour:
- One clock, clk_50. Reset is asynchronous and active-high on `reset`.
- Reset values:
  - all drive outputs 0
  - turn_grant = 0, hold_grant = 0, fault = 0, owner = 0
  - state = DEAD with counter = 0 and pending target = LF
- States: DEAD, LF, TURN, HOLD, FAULT.
- All outputs are registered. In an owning state, drive pins equal that owner's inputs delayed by 1 cycle.
- LF:
  - l_motor = lf_l_motor, r_motor = lf_r_motor, gndl = gndr = 0; owner = 1.
  - hold_req = 1 → target = HOLD, go to DEAD. Checked first, so it wins if both requests rise in the same cycle.
  - else turn_req = 1 → target = TURN, go to DEAD.
- DEAD:
  - All drive pins 0; owner = 0; both grants 0.
  - Counter increments from 0. On the cycle the counter reaches DEADTIME_CYC-1, go to target and clear the counter.
  - If the target's request drops during DEAD, the target reverts to LF.
  - If hold_req rises during a DEAD aimed at TURN, the target switches to HOLD and the counter is not restarted.
- TURN:
  - Drive = turn_* inputs; turn_grant = 1; owner = 2.
  - The counter runs as the watchdog.
  - Exit conditions:
    - turn_done = 1 or turn_req = 0 → target = LF, go to DEAD.
    - counter reaches TIMEOUT_CYC-1 before that → go to FAULT.
  - hold_req during TURN is deferred, never preempting. After the turn's DEAD, the target is HOLD if hold_req is still high, else LF.
- HOLD:
  - Drive pins 0; hold_grant = 1; owner = 3.
  - hold_req = 0 → if turn_req = 1 the target is TURN, else LF; go to DEAD.
- FAULT:
  - All drive pins 0; fault = 1; grants 0; owner = 0.
  - Only reset exits.
- Grants assert on the first cycle of the owning state and drop on the cycle the state leaves.
- The counter saturates; it never wraps.
- Reset mid-operation: outputs go to 0 immediately (asynchronously) and fault clears.

Optional Feature:
- Macro SB_MOTOR_BRAKE_EN.
- When defined: in DEAD and HOLD, gndl = gndr = 1 with l_motor = r_motor = 0 (active brake); in FAULT, gndl = gndr = 1.
- When undefined: all four pins are 0 in those states (coast).
- No other behaviour changes.

Test Plan:
- Bench parameters: DEADTIME_CYC = 4, TIMEOUT_CYC = 20.
- Reset release, lf_l_motor = 1, lf_r_motor = 0 → pins 0 for 4 cycles (owner 0), then owner = 1 and l_motor = 1, r_motor = 0 with 1-cycle latency.
- In LF, turn_req = 1 with turn_l_motor = 1, turn_gndr = 1 → 4 dead cycles, then turn_grant = 1, owner = 2, l_motor = 1, gndr = 1. Pulse turn_done → 4 dead cycles, back to owner 1.
- turn_req and hold_req rise in the same cycle → owner goes to 3 after 4 dead cycles and turn_grant stays 0. Drop hold_req while turn_req is still 1 → 4 dead cycles, then owner = 2.
- In TURN, raise hold_req → owner stays 2 until turn_done, then DEAD, then owner = 3 with hold_grant = 1.
- turn_req held without turn_done → fault = 1 and pins 0 exactly 20 cycles after turn_grant rose. Fault persists after turn_req drops and clears only on reset.
- Assert reset mid-TURN → pins and grants go to 0 in the same cycle, without waiting for a clock edge. With SB_MOTOR_BRAKE_EN defined, gndl = gndr = 1 during DEAD and HOLD.

Source files
------------

// File: rtl/sb_motor_arbiter.sv
// Motor pin arbiter: line follower / turn engine / hold requester with dead time and turn watchdog.
// Optional SB_MOTOR_BRAKE_EN: drive both ground pins high in DEAD, HOLD and FAULT (active brake).
module sb_motor_arbiter #(
    parameter int unsigned DEADTIME_CYC = 2500,
    parameter int unsigned TIMEOUT_CYC  = 25000000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       lf_l_motor,
    input  logic       lf_r_motor,
    input  logic       turn_req,
    input  logic       turn_l_motor,
    input  logic       turn_r_motor,
    input  logic       turn_gndl,
    input  logic       turn_gndr,
    input  logic       turn_done,
    output logic       turn_grant,
    input  logic       hold_req,
    output logic       hold_grant,
    output logic       l_motor,
    output logic       r_motor,
    output logic       gndl,
    output logic       gndr,
    output logic [1:0] owner,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_DEAD  = 3'd0,
        ST_LF    = 3'd1,
        ST_TURN  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef SB_MOTOR_BRAKE_EN
    localparam logic BRAKE = 1'b1;
`else
    localparam logic BRAKE = 1'b0;
`endif

    state_t           state, state_nx;
    state_t           target, target_nx;
    state_t           dead_tgt;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;

    logic       l_nx, r_nx, gl_nx, gr_nx;
    logic       tg_nx, hg_nx, fault_nx;
    logic [1:0] owner_nx;

    // State, pending target and shared dead-time/watchdog counter
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state  <= ST_DEAD;
            target <= ST_LF;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
        end
    end

    // Next-state, target and counter logic
    always_comb begin
        state_nx  = state;
        target_nx = target;
        cnt_nx    = cnt;
        dead_tgt  = target;
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

        case (state)
            ST_DEAD: begin
                // Hold may steal a pending turn without restarting the dead time
                if (target == ST_TURN && hold_req)
                    dead_tgt = ST_HOLD;
                else if (target == ST_TURN && !turn_req)
                    dead_tgt = ST_LF;
                else if (target == ST_HOLD && !hold_req)
                    dead_tgt = ST_LF;

                if (cnt >= DEAD_LAST) begin
                    // A hold deferred during a turn is honoured here
                    if (dead_tgt == ST_LF && hold_req)
                        state_nx = ST_HOLD;
                    else
                        state_nx = dead_tgt;
                    target_nx = ST_LF;
                    cnt_nx    = '0;
                end else begin
                    target_nx = dead_tgt;
                    cnt_nx    = cnt_inc;
                end
            end
            ST_LF: begin
                if (hold_req) begin
                    target_nx = ST_HOLD;
                    state_nx  = ST_DEAD;
                    cnt_nx    = '0;
                end else if (turn_req) begin
                    target_nx = ST_TURN;
                    state_nx  = ST_DEAD;
                    cnt_nx    = '0;
                end
            end
            ST_TURN: begin
                if (turn_done || !turn_req) begin
                    target_nx = ST_LF;
                    state_nx  = ST_DEAD;
                    cnt_nx    = '0;
                end else if (cnt >= TO_LAST) begin
                    state_nx = ST_FAULT;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (!hold_req) begin
                    target_nx = turn_req ? ST_TURN : ST_LF;
                    state_nx  = ST_DEAD;
                    cnt_nx    = '0;
                end
            end
            ST_FAULT: begin
                state_nx = ST_FAULT;
            end
            default: begin
                state_nx = ST_FAULT;
            end
        endcase
    end

    // Output values for the state being entered, so grants track state exactly
    always_comb begin
        l_nx     = 1'b0;
        r_nx     = 1'b0;
        gl_nx    = 1'b0;
        gr_nx    = 1'b0;
        tg_nx    = 1'b0;
        hg_nx    = 1'b0;
        fault_nx = 1'b0;
        owner_nx = 2'd0;

        case (state_nx)
            ST_LF: begin
                l_nx     = lf_l_motor;
                r_nx     = lf_r_motor;
                owner_nx = 2'd1;
            end
            ST_TURN: begin
                l_nx     = turn_l_motor;
                r_nx     = turn_r_motor;
                gl_nx    = turn_gndl;
                gr_nx    = turn_gndr;
                tg_nx    = 1'b1;
                owner_nx = 2'd2;
            end
            ST_HOLD: begin
                gl_nx    = BRAKE;
                gr_nx    = BRAKE;
                hg_nx    = 1'b1;
                owner_nx = 2'd3;
            end
            ST_FAULT: begin
                gl_nx    = BRAKE;
                gr_nx    = BRAKE;
                fault_nx = 1'b1;
            end
            default: begin
                gl_nx = BRAKE;
                gr_nx = BRAKE;
            end
        endcase
    end

    // Registered pin drive, grants, owner and sticky fault
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            l_motor    <= 1'b0;
            r_motor    <= 1'b0;
            gndl       <= 1'b0;
            gndr       <= 1'b0;
            turn_grant <= 1'b0;
            hold_grant <= 1'b0;
            fault      <= 1'b0;
            owner      <= 2'd0;
        end else begin
            l_motor    <= l_nx;
            r_motor    <= r_nx;
            gndl       <= gl_nx;
            gndr       <= gr_nx;
            turn_grant <= tg_nx;
            hold_grant <= hg_nx;
            fault      <= fault_nx;
            owner      <= owner_nx;
        end
    end

endmodule

// File: tb/tb_sb_motor_arbiter.sv
// Scoreboard bench for sb_motor_arbiter with DEADTIME_CYC=4, TIMEOUT_CYC=20.
module tb_sb_motor_arbiter;

`ifdef SB_MOTOR_BRAKE_EN
    localparam logic B = 1'b1;
`else
    localparam logic B = 1'b0;
`endif

    // Observed vector: {fault, hold_grant, turn_grant, owner[1:0], l, r, gndl, gndr}
    localparam logic [8:0] Z_VEC = 9'd0;
    localparam logic [8:0] D_VEC = {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, B, B};
    localparam logic [8:0] H_VEC = {1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, B, B};
    localparam logic [8:0] F_VEC = {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, B, B};

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       lf_l_motor, lf_r_motor;
    logic       turn_req, turn_l_motor, turn_r_motor, turn_gndl, turn_gndr, turn_done;
    logic       turn_grant, hold_req, hold_grant;
    logic       l_motor, r_motor, gndl, gndr;
    logic [1:0] owner;
    logic       fault;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    always #5 clk_50 = ~clk_50;

    sb_motor_arbiter #(.DEADTIME_CYC(4), .TIMEOUT_CYC(20), .CNT_W(5)) dut (
        .clk_50(clk_50), .reset(reset),
        .lf_l_motor(lf_l_motor), .lf_r_motor(lf_r_motor),
        .turn_req(turn_req), .turn_l_motor(turn_l_motor), .turn_r_motor(turn_r_motor),
        .turn_gndl(turn_gndl), .turn_gndr(turn_gndr), .turn_done(turn_done),
        .turn_grant(turn_grant), .hold_req(hold_req), .hold_grant(hold_grant),
        .l_motor(l_motor), .r_motor(r_motor), .gndl(gndl), .gndr(gndr),
        .owner(owner), .fault(fault)
    );

    function automatic logic [8:0] pack();
        return {fault, hold_grant, turn_grant, owner, l_motor, r_motor, gndl, gndr};
    endfunction

    function automatic logic [8:0] lf_vec(input logic l, input logic r);
        return {1'b0, 1'b0, 1'b0, 2'd1, l, r, 1'b0, 1'b0};
    endfunction

    function automatic logic [8:0] t_vec(input logic l, input logic r, input logic gl, input logic gr);
        return {1'b0, 1'b0, 1'b1, 2'd2, l, r, gl, gr};
    endfunction

    task automatic test_reset();
        logic [8:0] obs, exp;
        reset = 1'b1;
        lf_l_motor = 1'b1; lf_r_motor = 1'b0;
        turn_req = 0; turn_l_motor = 0; turn_r_motor = 0; turn_gndl = 0; turn_gndr = 0;
        turn_done = 0; hold_req = 0;
        sb.push_back(Z_VEC);
        repeat (2) @(negedge clk_50);
        obs = pack(); exp = sb.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, exp); end
        reset = 1'b0;
        repeat (3) sb.push_back(D_VEC);
        repeat (3) sb.push_back(lf_vec(1'b1, 1'b0));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL startup c=%0d got=%b want=%b", c, obs, exp); end
        end
    endtask

    task automatic test_lf();
        logic [8:0] obs, exp;
        lf_l_motor = 1'b0; lf_r_motor = 1'b1;
        repeat (2) sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL lf_follow c=%0d got=%b want=%b", c, obs, exp); end
        end
    endtask

    task automatic test_turn();
        logic [8:0] obs, exp;
        turn_l_motor = 1; turn_r_motor = 0; turn_gndl = 0; turn_gndr = 1; turn_req = 1;
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(t_vec(1, 0, 0, 1));
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL turn c=%0d got=%b want=%b", c, obs, exp); end
            if (c == 6) turn_done = 1;
            if (c == 7) begin turn_done = 0; turn_req = 0; end
        end
    endtask

    task automatic test_same_cycle();
        logic [8:0] obs, exp;
        turn_req = 1; hold_req = 1;
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(H_VEC);
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(t_vec(1, 0, 0, 1));
        repeat (4) sb.push_back(D_VEC);
        sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL same_cycle c=%0d got=%b want=%b", c, obs, exp); end
            if (c == 6) hold_req = 0;
            if (c == 12) turn_done = 1;
            if (c == 13) begin turn_done = 0; turn_req = 0; end
        end
    endtask

    task automatic test_deferred_hold();
        logic [8:0] obs, exp;
        turn_req = 1;
        repeat (4) sb.push_back(D_VEC);
        repeat (4) sb.push_back(t_vec(1, 0, 0, 1));
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(H_VEC);
        repeat (4) sb.push_back(D_VEC);
        sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL deferred_hold c=%0d got=%b want=%b", c, obs, exp); end
            if (c == 5) hold_req = 1;
            if (c == 8) turn_done = 1;
            if (c == 9) begin turn_done = 0; turn_req = 0; end
            if (c == 14) hold_req = 0;
        end
    endtask

    task automatic test_watchdog();
        logic [8:0] obs, exp;
        turn_req = 1;
        repeat (4) sb.push_back(D_VEC);
        repeat (20) sb.push_back(t_vec(1, 0, 0, 1));
        repeat (6) sb.push_back(F_VEC);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL watchdog c=%0d got=%b want=%b", c, obs, exp); end
            if (c == 26) turn_req = 0;
        end
    endtask

    task automatic test_fault_reset();
        logic [8:0] obs, exp;
        #2 reset = 1'b1;
        sb.push_back(Z_VEC);
        #1;
        obs = pack(); exp = sb.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL fault_async_clear got=%b want=%b", obs, exp); end
        @(negedge clk_50);
        reset = 1'b0;
        repeat (3) sb.push_back(D_VEC);
        repeat (2) sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL fault_recover c=%0d got=%b want=%b", c, obs, exp); end
        end
    endtask

    task automatic test_reset_mid_turn();
        logic [8:0] obs, exp;
        turn_req = 1;
        repeat (4) sb.push_back(D_VEC);
        repeat (2) sb.push_back(t_vec(1, 0, 0, 1));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL mid_turn_pre c=%0d got=%b want=%b", c, obs, exp); end
        end
        #2 reset = 1'b1;
        sb.push_back(Z_VEC);
        #1;
        obs = pack(); exp = sb.pop_front(); total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_turn_async got=%b want=%b", obs, exp); end
        @(negedge clk_50);
        reset = 1'b0; turn_req = 0;
        repeat (3) sb.push_back(D_VEC);
        repeat (2) sb.push_back(lf_vec(1'b0, 1'b1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_50);
            obs = pack(); exp = sb.pop_front(); total++;
            if (obs !== exp) begin bad++; $display("FAIL mid_turn_recover c=%0d got=%b want=%b", c, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_lf();
        test_turn();
        test_same_cycle();
        test_deferred_hold();
        test_watchdog();
        test_fault_reset();
        test_reset_mid_turn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
